// File: rtl/gpio_reg_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the GPIO register file.
// A granted transaction runs IDLE -> ACCESS -> (WAIT x RD_LAT for reads) -> ACK.
module gpio_reg_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_r_wn,
  input  logic [4:2]  m0_addr,
  input  logic [3:0]  m0_wben,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_r_wn,
  input  logic [4:2]  m1_addr,
  input  logic [3:0]  m1_wben,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [4:2]  rf_addr,
  output logic [3:0]  rf_wben,
  output logic        rf_r_wn,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata,
  output logic        busy,
  output logic        gnt_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t      state, state_nxt;
  logic        cmd_r_wn;
  logic [3:0]  cmd_wben;
  logic [1:0]  cnt;
  logic        grant_any;
  logic        grant_sel;
  logic        capture;

  // Round-robin: on a tie the master that did not own the last transaction wins.
  always_comb begin
    grant_any = m0_req | m1_req;
    if (m0_req && m1_req) grant_sel = ~gnt_id;
    else                  grant_sel = m1_req;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:   if (grant_any) state_nxt = ACCESS;
      ACCESS: begin
        if (cmd_r_wn && LAT != 2'd0) state_nxt = WAIT;
        else begin
          state_nxt = ACK;
          capture   = cmd_r_wn;
        end
      end
      WAIT: begin
        if (cnt == 2'd1) begin
          state_nxt = ACK;
          capture   = 1'b1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from state so a reset forces them inactive immediately.
  always_comb begin
    rf_wben = (state == ACCESS && !cmd_r_wn) ? cmd_wben : 4'b0000;
    rf_r_wn = (state == ACCESS) ? cmd_r_wn : 1'b1;
    m0_ack  = (state == ACK) && !gnt_id;
    m1_ack  = (state == ACK) &&  gnt_id;
    busy    = (state != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the read-data holding registers are reset too; they are observable outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_id   <= 1'b1;
      cmd_r_wn <= 1'b1;
      cmd_wben <= 4'b0000;
      rf_addr  <= 3'b000;
      rf_wdata <= 32'h0;
      cnt      <= 2'd0;
      m0_rdata <= 32'h0;
      m1_rdata <= 32'h0;
    end else begin
      if (state == IDLE && grant_any) begin
        gnt_id   <= grant_sel;
        cmd_r_wn <= grant_sel ? m1_r_wn  : m0_r_wn;
        cmd_wben <= grant_sel ? m1_wben  : m0_wben;
        rf_addr  <= grant_sel ? m1_addr  : m0_addr;
        rf_wdata <= grant_sel ? m1_wdata : m0_wdata;
      end
      if (state == ACCESS) cnt <= LAT;
      else if (state == WAIT) cnt <= cnt - 2'd1;
      if (capture) begin
        if (gnt_id) m1_rdata <= rf_rdata;
        else        m0_rdata <= rf_rdata;
      end
    end
  end

endmodule
